spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 187 ++++++++++++++++++
 tb/tb_spi_master.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//   Frame-oriented SPI master.  A 10-bit command word (2-bit command + 8-bit
//   payload) is shifted out MSB first behind a one-cycle START slot.  A
//   read-data command (cmd[9:8] == 2'b11) is followed by RD_WAIT turnaround
//   cycles and eight MISO samples that are assembled MSB first into rd_data.
//   Every frame ends with a one-cycle STOP that raises SS_n and pulses done.
//
// Parameters
//   RD_WAIT   cycles between the last MOSI bit of a read-data frame and the
//             first MISO sample (1..15)
//
// Ports
//   clk       system clock, all logic on the rising edge
//   rst_n     synchronous active-low reset
//   start     frame request, accepted only while idle
//   cmd_word  [9:8] command (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data),
//             [7:0] payload
//   MISO      serial data from the slave, MSB first
//   abort     (SPI_MASTER_ABORT_EN only) cut the current frame short
//   busy      high from the cycle after acceptance until idle again
//   done      one-cycle pulse in the STOP cycle
//   rd_data   byte received in the last completed read-data frame
//   rd_valid  one-cycle pulse with done when rd_data was just updated
//   SS_n      slave select, active-low
//   MOSI      serial data to the slave, MSB first
//
// Configuration
//   SPI_MASTER_ABORT_EN  when defined adds the abort input; an abort in
//                        START/SHIFT/WAIT/RECV jumps to STOP with done but
//                        without rd_valid and leaves rd_data untouched.
// -----------------------------------------------------------------------------
module spi_master #(
  parameter int RD_WAIT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [9:0] cmd_word,
  input  logic       MISO,
`ifdef SPI_MASTER_ABORT_EN
  input  logic       abort,
`endif
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       SS_n,
  output logic       MOSI
);

  typedef enum logic [2:0] {IDLE, START, SHIFT, WAIT, RECV, STOP} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(RD_WAIT - 1);

  state_t     r_state;
  logic [9:0] r_shift;
  logic [3:0] r_cnt;
  logic [7:0] r_rx;
  logic       r_isRead;

  logic       w_abort;
  logic       w_abortHit;
  logic [7:0] w_rxNext;

`ifdef SPI_MASTER_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Abort only matters while SS_n is low; IDLE and STOP ignore it.
  assign w_abortHit = w_abort && (r_state inside {START, SHIFT, WAIT, RECV});

  // Byte as it will look once the current MISO bit is shifted in.
  assign w_rxNext = {r_rx[6:0], MISO};

  // Single FSM with registered outputs: every output is assigned on the edge
  // that enters the state it belongs to, so SS_n/MOSI/done/rd_valid line up
  // exactly with the state the slave sees.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_rx     <= '0;
      r_isRead <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      SS_n     <= 1'b1;
      MOSI     <= 1'b0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      if (w_abortHit) begin
        r_state <= STOP;
        r_cnt   <= '0;
        SS_n    <= 1'b1;
        MOSI    <= 1'b0;
        done    <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            SS_n <= 1'b1;
            MOSI <= 1'b0;
            busy <= 1'b0;
            if (start) begin
              // The command type is kept separately because the shift
              // register loses cmd[9:8] while the payload goes out.
              r_shift  <= cmd_word;
              r_isRead <= (cmd_word[9:8] == 2'b11);
              r_cnt    <= '0;
              r_state  <= START;
              SS_n     <= 1'b0;
              MOSI     <= cmd_word[9];
              busy     <= 1'b1;
            end
          end
          START: begin
            // cmd[9] is presented twice: once in START, once in SHIFT.
            r_state <= SHIFT;
            MOSI    <= r_shift[9];
            r_shift <= {r_shift[8:0], 1'b0};
            r_cnt   <= '0;
          end
          SHIFT: begin
            if (r_cnt == 4'd9) begin
              r_cnt <= '0;
              MOSI  <= 1'b0;
              if (r_isRead) begin
                r_state <= WAIT;
              end else begin
                r_state <= STOP;
                SS_n    <= 1'b1;
                done    <= 1'b1;
              end
            end else begin
              MOSI    <= r_shift[9];
              r_shift <= {r_shift[8:0], 1'b0};
              r_cnt   <= r_cnt + 4'd1;
            end
          end
          WAIT: begin
            MOSI <= 1'b0;
            if (r_cnt == WAIT_LAST) begin
              r_cnt   <= '0;
              r_state <= RECV;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
          RECV: begin
            MOSI <= 1'b0;
            r_rx <= w_rxNext;
            if (r_cnt == 4'd7) begin
              r_cnt    <= '0;
              r_state  <= STOP;
              SS_n     <= 1'b1;
              done     <= 1'b1;
              rd_data  <= w_rxNext;
              rd_valid <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
          STOP: begin
            // start is not looked at here, which guarantees a second
            // SS_n-high cycle (the following IDLE) between frames.
            r_state <= IDLE;
            SS_n    <= 1'b1;
            MOSI    <= 1'b0;
            busy    <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            SS_n    <= 1'b1;
            MOSI    <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
//   Directed bench for spi_master.  A frame-level model (frame offset k from
//   the accepting edge, frame length L) predicts every output each cycle; a
//   capture process measures SS_n-low runs, MOSI bit streams and pulse counts
//   so that directed tests can be pinned against hand-computed literals.
// -----------------------------------------------------------------------------
module tb_spi_master;

  localparam int RD_WAIT = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [9:0] cmd_word;
  logic       MISO;
  logic       abort;
  logic       busy;
  logic       done;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       SS_n;
  logic       MOSI;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_master #(.RD_WAIT(RD_WAIT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .cmd_word (cmd_word),
    .MISO     (MISO),
`ifdef SPI_MASTER_ABORT_EN
    .abort    (abort),
`endif
    .busy     (busy),
    .done     (done),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .SS_n     (SS_n),
    .MOSI     (MOSI)
  );

  // Frame model: k counts edges since the accepting edge, L is the STOP offset.
  bit         mValid   = 1'b0;
  bit         mActive  = 1'b0;
  bit         mRead    = 1'b0;
  bit         mAborted = 1'b0;
  int         mK = 0;
  int         mL = 0;
  logic [9:0] mCmd = '0;
  logic [7:0] mRx = '0;
  logic [7:0] mRdData = '0;
  logic [7:0] misoByte = '0;

  // Measurements for the literal checks.
  bit          prevSs = 1'b1;
  int          lowCnt = 0;
  int          highCnt = 0;
  int          lastLow = 0;
  int          lastHigh = 0;
  logic [31:0] mosiCap = '0;
  logic [31:0] lastMosi = '0;
  int          doneCnt = 0;
  int          rvCnt = 0;
  int          bothCnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model update on each rising edge, from the inputs the bench drove.
  always @(posedge clk) begin
    if (!rst_n) begin
      mValid  = 1'b1;
      mActive = 1'b0;
      mRdData = '0;
    end else if (mValid) begin
      if (!mActive) begin
        if (start) begin
          mActive  = 1'b1;
          mK       = 0;
          mCmd     = cmd_word;
          mRead    = (cmd_word[9:8] == 2'b11);
          mL       = mRead ? 19 + RD_WAIT : 11;
          mAborted = 1'b0;
          mRx      = '0;
        end
      end else begin
        mK++;
        if (mK == mL + 1) begin
          mActive = 1'b0;
        end else begin
          if (abort && (mK - 1) < mL) begin
            mL       = mK;
            mAborted = 1'b1;
          end else if (mRead && mK >= 12 + RD_WAIT && mK <= 19 + RD_WAIT) begin
            mRx = {mRx[6:0], MISO};
          end
          if (mK == mL && mRead && !mAborted) mRdData = mRx;
        end
      end
    end
  end

  // Slave model: MISO carries misoByte MSB first during the eight RECV cycles.
  always @(negedge clk) begin
    if (mActive && mRead && mK >= 11 + RD_WAIT && mK <= 18 + RD_WAIT)
      MISO = misoByte[7 - (mK - 11 - RD_WAIT)];
    else
      MISO = 1'b1;
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic expSs, expMosi, expBusy, expDone, expRv;
    if (mValid) begin
      expSs = 1'b1; expMosi = 1'b0; expBusy = 1'b0; expDone = 1'b0; expRv = 1'b0;
      if (mActive) begin
        expBusy = 1'b1;
        if (mK < mL) begin
          expSs = 1'b0;
          if (mK == 0) expMosi = mCmd[9];
          else if (mK <= 10) expMosi = mCmd[10 - mK];
        end else begin
          expDone = 1'b1;
          expRv   = mRead && !mAborted;
        end
      end
      checkOutput("SS_n", 32'(SS_n), 32'(expSs));
      checkOutput("MOSI", 32'(MOSI), 32'(expMosi));
      checkOutput("busy", 32'(busy), 32'(expBusy));
      checkOutput("done", 32'(done), 32'(expDone));
      checkOutput("rd_valid", 32'(rd_valid), 32'(expRv));
      checkOutput("rd_data", 32'(rd_data), 32'(mRdData));
    end
  end

  // Run-length and pulse capture.
  always @(negedge clk) begin
    if (mValid) begin
      if (SS_n === 1'b0) begin
        if (prevSs) begin
          lowCnt   = 0;
          mosiCap  = '0;
          lastHigh = highCnt;
        end
        lowCnt++;
        mosiCap = {mosiCap[30:0], MOSI};
        prevSs  = 1'b0;
      end else begin
        if (!prevSs) begin
          lastLow  = lowCnt;
          lastMosi = mosiCap;
          highCnt  = 0;
        end
        highCnt++;
        prevSs = 1'b1;
      end
      if (done === 1'b1) doneCnt++;
      if (rd_valid === 1'b1) rvCnt++;
      if (done === 1'b1 && rd_valid === 1'b1) bothCnt++;
    end
  end

  // Present a frame request for one cycle (or keep it high), then change
  // cmd_word so that a late change would corrupt the frame if it leaked in.
  task automatic applyStimulus(input logic [9:0] cmd, input logic [9:0] afterCmd,
                               input bit hold);
    @(negedge clk);
    start    = 1'b1;
    cmd_word = cmd;
    @(negedge clk);
    if (!hold) start = 1'b0;
    cmd_word = afterCmd;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (mActive && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (mActive) begin
      checks++;
      errors++;
      $display("[TB] FAIL idleTimeout: frame still active after %0d cycles", n);
    end
    #1;
  endtask

  initial begin
    int d0, r0, b0, n;
    rst_n    = 1'b0;
    start    = 1'b0;
    cmd_word = '0;
    abort    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rstSS_n", 32'(SS_n), 32'd1);
    checkOutput("rstMOSI", 32'(MOSI), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstRdValid", 32'(rd_valid), 32'd0);
    checkOutput("rstRdData", 32'(rd_data), 32'h00);

    // Read-data frame with payload bits, slave returns C3.
    $display("[TB] read-data frame 3A5, slave byte C3");
    misoByte = 8'hC3;
    applyStimulus(10'h3A5, 10'h000, 1'b0);
    waitIdle();
    checkOutput("rdC3Low", 32'(lastLow), 32'd21);
    checkOutput("rdC3Mosi", lastMosi, 32'({11'b11110100101, 10'b0}));
    checkOutput("rdC3Data", 32'(rd_data), 32'hC3);

    // Read-data frame 300, slave returns 5A.
    $display("[TB] read-data frame 300, slave byte 5A");
    misoByte = 8'h5A;
    d0 = doneCnt; r0 = rvCnt; b0 = bothCnt;
    applyStimulus(10'h300, 10'h0FF, 1'b0);
    waitIdle();
    checkOutput("rd5ALow", 32'(lastLow), 32'd21);
    checkOutput("rd5AMosi", lastMosi, 32'({11'b11100000000, 10'b0}));
    checkOutput("rd5AData", 32'(rd_data), 32'h5A);
    checkOutput("rd5ADone", 32'(doneCnt - d0), 32'd1);
    checkOutput("rd5AValid", 32'(rvCnt - r0), 32'd1);
    checkOutput("rd5ATogether", 32'(bothCnt - b0), 32'd1);

    // Write-address frame; rd_data must hold.
    $display("[TB] write-address frame 0A5");
    d0 = doneCnt; r0 = rvCnt;
    applyStimulus(10'b00_1010_0101, 10'h3FF, 1'b0);
    waitIdle();
    checkOutput("wrLow", 32'(lastLow), 32'd11);
    checkOutput("wrMosi", lastMosi, 32'(11'b00010100101));
    checkOutput("wrDone", 32'(doneCnt - d0), 32'd1);
    checkOutput("wrNoValid", 32'(rvCnt - r0), 32'd0);
    checkOutput("wrHoldData", 32'(rd_data), 32'h5A);

    // start held while busy, cmd_word changed to 155 after acceptance.
    $display("[TB] start held with cmd change to 155");
    applyStimulus(10'h0F0, 10'h155, 1'b1);
    waitIdle();
    checkOutput("ignLow", 32'(lastLow), 32'd11);
    checkOutput("ignMosi", lastMosi, 32'(11'b00011110000));
    @(negedge clk);
    start = 1'b0;
    waitIdle();
    checkOutput("ign2Mosi", lastMosi, 32'(11'b00101010101));
    checkOutput("ignGap", 32'(lastHigh), 32'd2);

    // Back-to-back rd-addr frames with start held continuously.
    $display("[TB] back-to-back rd-addr 2A7");
    applyStimulus(10'h2A7, 10'h2A7, 1'b1);
    waitIdle();
    checkOutput("b2b1Mosi", lastMosi, 32'(11'b11010100111));
    @(negedge clk);
    start = 1'b0;
    waitIdle();
    checkOutput("b2b2Mosi", lastMosi, 32'(11'b11010100111));
    checkOutput("b2b2Low", 32'(lastLow), 32'd11);
    checkOutput("b2bGap", 32'(lastHigh), 32'd2);

`ifdef SPI_MASTER_ABORT_EN
    // Abort in RECV cycle 3 of a read-data frame.
    $display("[TB] abort during RECV");
    misoByte = 8'hFF;
    applyStimulus(10'h300, 10'h000, 1'b0);
    n = 0;
    while (!(mActive && mK == 11 + RD_WAIT + 3) && n < 100) begin
      @(negedge clk);
      n++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    checkOutput("abtSS_n", 32'(SS_n), 32'd1);
    checkOutput("abtDone", 32'(done), 32'd1);
    checkOutput("abtNoValid", 32'(rd_valid), 32'd0);
    checkOutput("abtData", 32'(rd_data), 32'h5A);
    waitIdle();
`endif

    // Reset for two cycles in the middle of SHIFT.
    $display("[TB] reset mid-SHIFT");
    d0 = doneCnt; r0 = rvCnt;
    applyStimulus(10'h1FF, 10'h000, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("midRstSS_n", 32'(SS_n), 32'd1);
    checkOutput("midRstMOSI", 32'(MOSI), 32'd0);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstData", 32'(rd_data), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    checkOutput("midRstNoDone", 32'(doneCnt - d0), 32'd0);
    checkOutput("midRstNoValid", 32'(rvCnt - r0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
